// File: rtl/fdiv_pipe.sv
// fdiv_pipe: pipelined IEEE-754 single-precision divider.
// Stage 0 unpacks and classifies operands; every stage retires a share of the
// 26 restoring-division quotient bits (24 significand + guard + round), and the
// last stage also normalises, rounds to nearest-even and packs the result.
// A single global stall holds every stage while the output waits on out_ready.
module fdiv_pipe #(
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag
);

    localparam int QBITS = 26;
    localparam int BASE  = QBITS / STAGES;
    localparam int EXTRA = QBITS % STAGES;

    // Runs n restoring-division steps. The partial remainder stays below twice
    // the divisor, so 25 bits hold it; the quotient shifts in from the right.
    function automatic logic [50:0] div_steps(input logic [24:0] r_in,
                                              input logic [25:0] q_in,
                                              input logic [23:0] d,
                                              input int          n);
        logic [24:0] r;
        logic [25:0] q;
        r = r_in;
        q = q_in;
        for (int i = 0; i < QBITS; i++) begin
            if (i < n) begin
                if (r >= {1'b0, d}) begin
                    r = r - {1'b0, d};
                    q = {q[24:0], 1'b1};
                end else begin
                    q = {q[24:0], 1'b0};
                end
                r = {r[23:0], 1'b0};
            end
        end
        return {r, q};
    endfunction

    // Normalise a quotient in [0.5, 2), round to nearest-even and pack.
    // Overflow saturates to infinity; anything below the normal range flushes
    // to signed zero.
    function automatic logic [31:0] round_pack(input logic              s,
                                               input logic signed [9:0] e_in,
                                               input logic [25:0]       q,
                                               input logic              sticky);
        logic [22:0]       frac;
        logic              g;
        logic              rs;
        logic              inc;
        logic              cy;
        logic signed [9:0] e;
        if (q[25]) begin
            frac = q[24:2];
            g    = q[1];
            rs   = q[0] | sticky;
            e    = e_in;
        end else begin
            frac = q[23:1];
            g    = q[0];
            rs   = sticky;
            e    = e_in - 10'sd1;
        end
        inc        = g & (rs | frac[0]);
        {cy, frac} = {1'b0, frac} + {23'd0, inc};
        e          = e + $signed({9'd0, cy});
        if (e >= 10'sd255) begin
            return {s, 8'hFF, 23'h0};
        end else if (e <= 10'sd0) begin
            return {s, 31'h0};
        end
        return {s, e[7:0], frac};
    endfunction

    logic advance;
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    logic [7:0]        ex1;
    logic [7:0]        ex2;
    logic              sgn_in;
    logic signed [9:0] exp_in;
    logic              spc_in;
    logic [31:0]       spcv_in;

    assign ex1 = x1[30:23];
    assign ex2 = x2[30:23];

    // Classify operands; the first matching special case decides the result.
    always_comb begin
        sgn_in  = x1[31] ^ x2[31];
        exp_in  = $signed({2'b00, ex1}) - $signed({2'b00, ex2}) + 10'sd127;
        spc_in  = 1'b1;
        spcv_in = {sgn_in, 8'hFF, 23'h0};
        if (ex1 == 8'hFF || ex2 == 8'hFF) begin
            spcv_in = {sgn_in, 8'hFF, 23'h0};
        end else if (ex2 == 8'h00) begin
            spcv_in = x1;
        end else if (ex1 == 8'h00) begin
            spcv_in = {sgn_in, 31'h0};
        end else begin
            spc_in  = 1'b0;
            spcv_in = 32'h0;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // Leftover quotient bits go to the earliest stages.
        localparam int NB = BASE + ((k < EXTRA) ? 1 : 0);

        logic              vld_i;
        logic              sgn_i;
        logic              spc_i;
        logic signed [9:0] exp_i;
        logic [31:0]       spcv_i;
        logic [TAG_W-1:0]  tag_i;
        logic [24:0]       rem_i;
        logic [25:0]       quo_i;
        logic [23:0]       dvs_i;
        logic [24:0]       rem_o;
        logic [25:0]       quo_o;

        if (k == 0) begin : g_src
            assign vld_i  = in_valid;
            assign sgn_i  = sgn_in;
            assign spc_i  = spc_in;
            assign exp_i  = exp_in;
            assign spcv_i = spcv_in;
            assign tag_i  = in_tag;
            assign rem_i  = {2'b01, x1[22:0]};
            assign quo_i  = '0;
            assign dvs_i  = {1'b1, x2[22:0]};
        end else begin : g_src
            assign vld_i  = g_stg[k-1].g_mid.vld_q;
            assign sgn_i  = g_stg[k-1].g_mid.sgn_q;
            assign spc_i  = g_stg[k-1].g_mid.spc_q;
            assign exp_i  = g_stg[k-1].g_mid.exp_q;
            assign spcv_i = g_stg[k-1].g_mid.spcv_q;
            assign tag_i  = g_stg[k-1].g_mid.tag_q;
            assign rem_i  = g_stg[k-1].g_mid.rem_q;
            assign quo_i  = g_stg[k-1].g_mid.quo_q;
            assign dvs_i  = g_stg[k-1].g_mid.dvs_q;
        end

        assign {rem_o, quo_o} = div_steps(rem_i, quo_i, dvs_i, NB);

        if (k < STAGES - 1) begin : g_mid
            logic              vld_q;
            logic              sgn_q;
            logic              spc_q;
            logic signed [9:0] exp_q;
            logic [31:0]       spcv_q;
            logic [TAG_W-1:0]  tag_q;
            logic [24:0]       rem_q;
            logic [25:0]       quo_q;
            logic [23:0]       dvs_q;

            // Pipeline register for this stage; holds while the output is stalled.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    sgn_q  <= 1'b0;
                    spc_q  <= 1'b0;
                    exp_q  <= '0;
                    spcv_q <= '0;
                    tag_q  <= '0;
                    rem_q  <= '0;
                    quo_q  <= '0;
                    dvs_q  <= '0;
                end else if (advance) begin
                    vld_q  <= vld_i;
                    sgn_q  <= sgn_i;
                    spc_q  <= spc_i;
                    exp_q  <= exp_i;
                    spcv_q <= spcv_i;
                    tag_q  <= tag_i;
                    rem_q  <= rem_o;
                    quo_q  <= quo_o;
                    dvs_q  <= dvs_i;
                end
            end
        end else begin : g_last
            // Output register: final quotient bits, rounding and packing.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    y         <= 32'h0;
                    out_tag   <= '0;
                end else if (advance) begin
                    out_valid <= vld_i;
                    if (vld_i) begin
                        out_tag <= tag_i;
                        y       <= spc_i ? spcv_i
                                         : round_pack(sgn_i, exp_i, quo_o, (rem_o != 25'd0));
                    end
                end
            end
        end
    end

endmodule

// File: doc/fdiv_pipe.md
Name: fdiv_pipe

Overview:
- Parametrised, fully pipelined IEEE-754 single-precision divider.
- Successor to the fixed-latency FPU `fdiv`. Adds:
  - configurable pipeline depth,
  - valid/ready handshaking with backpressure,
  - a pass-through tag,
  - correctly rounded (round-to-nearest-even) results.
- Sits in the FPU execute path. Accepts one operation per cycle when not stalled.

Parameters:
- STAGES, 4, pipeline depth and input-to-output latency in cycles. Legal range 2..14. Quotient bits are distributed evenly across stages; remainder bits go to the earliest stages.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept this cycle.
- x1  in  32  dividend, IEEE single.
- x2  in  32  divisor, IEEE single.
- in_tag  in  TAG_W  caller tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- y  out  32  quotient, IEEE single.
- out_tag  out  TAG_W  tag of the result on y.

Behaviour:
- Reset: while rst is high, all stage valid bits clear asynchronously. Effect on outputs:
  - out_valid=0,
  - y=32'h0,
  - out_tag=0,
  - in_ready=1 once rst deasserts.
- Reset mid-operation discards all in-flight ops; no partial result ever appears.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - in_ready = out_ready || !out_valid. This is a global stall: all stages hold when the output is valid and not accepted.
  - No bubble collapsing.
  - y and out_tag stay stable while out_valid && !out_ready.
- Latency: an op accepted at cycle N presents out_valid at cycle N+STAGES, provided no stall intervenes. Throughput is 1/cycle.
- Datapath:
  - Stage 1 unpacks the operands and classifies special cases.
  - Middle stages perform restoring division, producing 26 quotient bits (24 significand + guard + round). Sticky = (final remainder != 0).
  - Final stage normalises (quotient < 1 shifts left 1, exponent decrements), rounds RNE, and increments the exponent on mantissa carry-out.
- Sign: y[31] = x1[31] ^ x2[31], including zero and inf results.
- Exponent: e = e1 - e2 + 127, evaluated in a 10-bit signed intermediate.
  - After normalise/round, e >= 255 gives ±inf ({s, 8'hFF, 23'h0}).
  - e <= 0 gives signed zero (no denormal output).
- Special cases (checked in order, carried down the pipe as flags):
  - x1 or x2 exponent == 255 gives {s, 8'hFF, 23'h0}.
  - x2 exponent == 0 gives y = x1 unchanged (FPU convention; sign not altered).
  - x1 exponent == 0 gives {s, 31'h0}. Denormal inputs are flushed to zero.
- No X propagation: y must be fully defined for every valid output, whatever the input bits.

Test Plan:
- Basic division, STAGES=4, out_ready=1: x1=32'h40C00000 (6.0), x2=32'h40000000 (2.0), tag=3, accepted at cycle 0 -> out_valid at cycle 4, y=32'h40400000, out_tag=3.
- Rounding and streaming: back-to-back 1.0/3.0 (32'h3F800000/32'h40400000) then 2.0/3.0 (32'h40000000/32'h40400000) -> consecutive cycles show y=32'h3EAAAAAB then 32'h3F2AAAAB.
- Specials:
  - x1=32'h40490FDB, x2=32'h00000000 -> y=32'h40490FDB.
  - x1=32'h80000000, x2=32'h40000000 -> y=32'h80000000.
  - x1=32'h7F000000, x2=32'h3E800000 -> y=32'h7F800000.
  - x1=32'h00800000, x2=32'h40000000 -> y=32'h00000000.
- Backpressure: issue 6 ops with out_ready=0 -> in_ready falls when the first result is valid; y/out_tag stay constant for 5 stalled cycles. Then raise out_ready -> all 6 results emerge in order with correct tags, none lost or duplicated.
- Reset mid-flight: 3 ops in the pipe, assert rst for 1 cycle asynchronously -> out_valid=0 immediately. No stale result appears within the next STAGES+2 cycles.
- Random regression: 100000 random operand pairs at STAGES=2, 4 and 14, compared against the shortreal model (specials mapped as above) -> bit-exact match on every normal-range result.
